// File: rtl/vga_demo_pkg.sv
// Shared definitions for the VGA demo sequencer.
// Contents: FSM state encoding, mode index width, the mode-to-control
// mapping used by vga_core, and default timing constants.
package vga_demo_pkg;

  typedef enum logic {
    ST_AUTO   = 1'b0,
    ST_MANUAL = 1'b1
  } seq_state_t;

  localparam int MODE_W      = 2;
  localparam int FRAME_CNT_W = 5;

  localparam int DEF_NUM_MODES       = 4;
  localparam int DEF_DWELL_FRAMES    = 300;
  localparam int DEF_DEBOUNCE_CYCLES = 405000;  // 10 ms at 40.5 MHz
  localparam int DEF_LONG_FRAMES     = 90;

  typedef struct packed {
    logic color_3b;
    logic mode_bit;
  } mode_ctrl_t;

  // Mode index bit 1 selects the 3-bit colour path, bit 0 the pattern.
  function automatic mode_ctrl_t mode_to_ctrl(input logic [MODE_W-1:0] idx);
    mode_ctrl_t ctrl;
    ctrl.color_3b = idx[1];
    ctrl.mode_bit = idx[0];
    return ctrl;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-FF synchronizer, debounce counter, press pulse.
// Ports:
//   clk_40m_tree  in  clock
//   reset_loc     in  asynchronous active-high reset
//   btn_n         in  raw asynchronous active-low button
//   level         out debounced level, 1 = pressed
//   press         out one-cycle pulse on debounced released->pressed
// The debounced level only follows the synchronized input after it has
// disagreed with it for DEBOUNCE_CYCLES consecutive clocks.
module btn_debounce
  import vga_demo_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk_40m_tree,
  input  logic reset_loc,
  input  logic btn_n,
  output logic level,
  output logic press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_reg;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             level_reg, level_next;
  logic             press_reg, press_next;
  logic             synced;

  // Synchronizer holds the raw (active-low) level; invert after it.
  assign synced = ~sync_reg[1];

  always_comb begin
    cnt_next   = cnt_reg;
    level_next = level_reg;
    press_next = 1'b0;
    if (synced == level_reg) begin
      // Any sample agreeing with the accepted level restarts the count.
      cnt_next = '0;
    end else if (cnt_reg == CNT_LAST) begin
      cnt_next   = '0;
      level_next = synced;
      press_next = synced;
    end else begin
      cnt_next = cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk_40m_tree or posedge reset_loc) begin
    if (reset_loc) begin
      sync_reg  <= 2'b11;  // released
      cnt_reg   <= '0;
      level_reg <= 1'b0;
      press_reg <= 1'b0;
    end else begin
      sync_reg  <= {sync_reg[0], btn_n};
      cnt_reg   <= cnt_next;
      level_reg <= level_next;
      press_reg <= press_next;
    end
  end

  assign level = level_reg;
  assign press = press_reg;

endmodule

// File: rtl/vga_demo_sequencer.sv
// Frame-synchronous demo-mode scheduler for vga_core.
// Ports:
//   clk_40m_tree  in  dot clock
//   reset_loc     in  asynchronous active-high reset
//   btn_next_n    in  raw active-low "next mode" button
//   vga_vs        in  vsync from the timing generator
//   mode_idx      out current mode 0..NUM_MODES-1
//   mode_bit      out mode_idx[0] for vga_core
//   color_3b      out mode_idx[1] for vga_core
//   auto_en       out 1 while cycling automatically
//   frame_tick    out one-cycle pulse per frame start
//   led_ok        out heartbeat, toggles every 32 frames
// Mode changes are only committed on frame_tick, so a frame never mixes
// two patterns. Requests collect in adv_pend between frame ticks.
module vga_demo_sequencer
  import vga_demo_pkg::*;
#(
  parameter int NUM_MODES       = DEF_NUM_MODES,
  parameter int DWELL_FRAMES    = DEF_DWELL_FRAMES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int LONG_FRAMES     = DEF_LONG_FRAMES,
  parameter bit VS_ACTIVE_HIGH  = 1'b1
) (
  input  logic              clk_40m_tree,
  input  logic              reset_loc,
  input  logic              btn_next_n,
  input  logic              vga_vs,
  output logic [MODE_W-1:0] mode_idx,
  output logic              mode_bit,
  output logic              color_3b,
  output logic              auto_en,
  output logic              frame_tick,
  output logic              led_ok
);

  localparam int HELD_W = $clog2(LONG_FRAMES + 1);
  localparam logic [MODE_W-1:0] LAST_MODE  = MODE_W'(NUM_MODES - 1);
  localparam logic [15:0]       DWELL_LAST = 16'(DWELL_FRAMES - 1);
  localparam logic [HELD_W-1:0] HELD_LAST  = HELD_W'(LONG_FRAMES - 1);

  // Vsync path
  logic [1:0] vs_sync_reg;
  logic       vs_prev_reg;
  logic       frame_tick_reg;
  logic       vs_active;

  // Button path
  logic btn_level;
  logic btn_press;

  // Sequencer state
  seq_state_t             state_reg, state_next;
  logic [15:0]            dwell_reg, dwell_next;
  logic [HELD_W-1:0]      held_reg, held_next;
  logic [FRAME_CNT_W-1:0] frame_cnt_reg, frame_cnt_next;
  logic                   led_reg, led_next;
  logic                   adv_pend_reg, adv_pend_next;
  logic [MODE_W-1:0]      mode_reg, mode_next;
  mode_ctrl_t             ctrl_reg, ctrl_next;
  logic                   dwell_expire;

  assign vs_active = (vs_sync_reg[1] == VS_ACTIVE_HIGH);

  // The vsync chain resets to the active level: a vsync already asserted
  // when reset releases then looks like a steady level, not a new edge.
  always_ff @(posedge clk_40m_tree or posedge reset_loc) begin
    if (reset_loc) begin
      vs_sync_reg    <= {2{VS_ACTIVE_HIGH}};
      vs_prev_reg    <= 1'b1;
      frame_tick_reg <= 1'b0;
    end else begin
      vs_sync_reg    <= {vs_sync_reg[0], vga_vs};
      vs_prev_reg    <= vs_active;
      frame_tick_reg <= vs_active & ~vs_prev_reg;
    end
  end

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_next (
    .clk_40m_tree(clk_40m_tree),
    .reset_loc   (reset_loc),
    .btn_n       (btn_next_n),
    .level       (btn_level),
    .press       (btn_press)
  );

  always_comb begin
    state_next     = state_reg;
    dwell_next     = dwell_reg;
    held_next      = held_reg;
    frame_cnt_next = frame_cnt_reg;
    led_next       = led_reg;
    adv_pend_next  = adv_pend_reg;
    mode_next      = mode_reg;
    dwell_expire   = (state_reg == ST_AUTO) && frame_tick_reg && (dwell_reg == DWELL_LAST);

    // Frame boundary: consume the pending request before new ones are
    // latched below, so a request raised on this very tick waits a frame.
    if (frame_tick_reg) begin
      adv_pend_next  = 1'b0;
      frame_cnt_next = frame_cnt_reg + 1'b1;
      if (frame_cnt_reg == '1) begin
        led_next = ~led_reg;
      end
      if (adv_pend_reg) begin
        mode_next = (mode_reg == LAST_MODE) ? '0 : mode_reg + 1'b1;
      end
    end

    case (state_reg)
      ST_AUTO: begin
        held_next = '0;
        if (frame_tick_reg) begin
          dwell_next = dwell_expire ? '0 : dwell_reg + 16'd1;
        end
        if (dwell_expire || btn_press) begin
          adv_pend_next = 1'b1;
        end
        if (btn_press) begin
          state_next = ST_MANUAL;
          dwell_next = '0;
        end
      end
      ST_MANUAL: begin
        dwell_next = '0;
        if (btn_press) begin
          adv_pend_next = 1'b1;
        end
        // A long hold returns to AUTO without requesting an advance.
        if (!btn_level) begin
          held_next = '0;
        end else if (frame_tick_reg) begin
          if (held_reg == HELD_LAST) begin
            held_next  = '0;
            state_next = ST_AUTO;
          end else begin
            held_next = held_reg + 1'b1;
          end
        end
      end
      default: begin
        state_next = ST_AUTO;
      end
    endcase

    ctrl_next = mode_to_ctrl(mode_next);
  end

  always_ff @(posedge clk_40m_tree or posedge reset_loc) begin
    if (reset_loc) begin
      state_reg     <= ST_AUTO;
      dwell_reg     <= '0;
      held_reg      <= '0;
      frame_cnt_reg <= '0;
      led_reg       <= 1'b0;
      adv_pend_reg  <= 1'b0;
      mode_reg      <= '0;
      ctrl_reg      <= '0;
    end else begin
      state_reg     <= state_next;
      dwell_reg     <= dwell_next;
      held_reg      <= held_next;
      frame_cnt_reg <= frame_cnt_next;
      led_reg       <= led_next;
      adv_pend_reg  <= adv_pend_next;
      mode_reg      <= mode_next;
      ctrl_reg      <= ctrl_next;
    end
  end

  assign mode_idx   = mode_reg;
  assign mode_bit   = ctrl_reg.mode_bit;
  assign color_3b   = ctrl_reg.color_3b;
  assign auto_en    = (state_reg == ST_AUTO);
  assign frame_tick = frame_tick_reg;
  assign led_ok     = led_reg;

endmodule

// File: tb/tb_vga_demo_sequencer.sv
// Self-checking bench for vga_demo_sequencer with a frame-level model.
module tb_vga_demo_sequencer;

  localparam int D  = 4;
  localparam int DW = 3;
  localparam int LG = 2;
  localparam int NM = 4;

  logic       clk = 1'b0;
  logic       reset_loc = 1'b1;
  logic       btn_next_n = 1'b1;
  logic       vga_vs = 1'b0;
  logic [1:0] mode_idx;
  logic       mode_bit, color_3b, auto_en, frame_tick, led_ok;

  vga_demo_sequencer #(
    .NUM_MODES      (NM),
    .DWELL_FRAMES   (DW),
    .DEBOUNCE_CYCLES(D),
    .LONG_FRAMES    (LG),
    .VS_ACTIVE_HIGH (1'b1)
  ) dut (
    .clk_40m_tree(clk),
    .reset_loc   (reset_loc),
    .btn_next_n  (btn_next_n),
    .vga_vs      (vga_vs),
    .mode_idx    (mode_idx),
    .mode_bit    (mode_bit),
    .color_3b    (color_3b),
    .auto_en     (auto_en),
    .frame_tick  (frame_tick),
    .led_ok      (led_ok)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int tick_cnt = 0;
  int mode_changes = 0;
  bit cmp_en = 0;
  bit vs_run = 0;
  int phase = 99;
  int frame_no = 0;

  // ---------------- behavioural model ----------------
  bit vs_h[$];
  bit bt_h[$];
  int m_mode, m_dwell, m_held, m_frames;
  bit m_auto, m_pend, m_deb, m_tick, m_press, m_led;

  always @(posedge clk or posedge reset_loc) begin
    bit t, p, expire, all_diff;
    if (reset_loc) begin
      vs_h = {1'b1, 1'b1, 1'b1, 1'b1};
      bt_h.delete();
      for (int k = 0; k < D + 2; k++) bt_h.push_back(1'b0);
      m_mode = 0; m_dwell = 0; m_held = 0; m_frames = 0;
      m_auto = 1; m_pend = 0; m_deb = 0; m_tick = 0; m_press = 0; m_led = 0;
    end else begin
      t = m_tick;
      p = m_press;
      expire = m_auto && t && (m_dwell == DW - 1);
      if (t) begin
        if (m_pend) m_mode = (m_mode + 1) % NM;
        m_pend = 0;
        m_frames = (m_frames + 1) % 32;
        if (m_frames == 0) m_led = !m_led;
      end
      if (m_auto) begin
        if (t) m_dwell = expire ? 0 : m_dwell + 1;
        if (expire || p) m_pend = 1;
        if (p) begin m_auto = 0; m_dwell = 0; end
      end else begin
        if (p) m_pend = 1;
        if (!m_deb) m_held = 0;
        else if (t) begin
          m_held = m_held + 1;
          if (m_held == LG) begin m_auto = 1; m_held = 0; m_dwell = 0; end
        end
      end
      // Frame tick: pin active two samples ago, inactive three samples ago.
      vs_h.push_back(vga_vs);
      void'(vs_h.pop_front());
      m_tick = vs_h[1] && !vs_h[0];
      // Debounce: the last D synchronized samples all disagree with the level.
      bt_h.push_back(!btn_next_n);
      void'(bt_h.pop_front());
      all_diff = 1;
      for (int k = 0; k < D; k++) if (bt_h[k] == m_deb) all_diff = 0;
      m_press = 0;
      if (all_diff) begin
        m_deb = !m_deb;
        m_press = m_deb;
      end
    end
  end

  // ---------------- vsync generator: 100-clock frames ----------------
  initial begin
    wait (vs_run);
    forever begin
      @(negedge clk);
      phase = (phase + 1) % 100;
      if (phase == 0) frame_no = frame_no + 1;
      vga_vs = (phase < 4);
    end
  end

  task automatic check(input string name, input int got, input int want);
    total = total + 1;
    if (got != want) begin
      bad = bad + 1;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic wait_at(input int f, input int p);
    int n = 0;
    do begin
      @(negedge clk);
      #1;
      n = n + 1;
    end while (!(frame_no == f && phase == p) && n < 20000);
    if (n >= 20000) begin
      total = total + 1;
      bad = bad + 1;
      $display("FAIL wait_at frame=%0d phase=%0d timed out", f, p);
    end
  endtask

  task automatic press_for(input int cycles);
    btn_next_n = 1'b0;
    repeat (cycles) @(negedge clk);
    btn_next_n = 1'b1;
  endtask

  initial begin
    fork
      begin : compare_loop
        logic [5:0] got, want;
        logic [1:0] prev_mode = 2'd0;
        forever begin
          @(negedge clk);
          if (cmp_en) begin
            got  = {mode_idx, mode_bit, color_3b, auto_en, frame_tick, led_ok};
            want = {2'(m_mode), 1'(m_mode % 2), 1'(m_mode / 2), m_auto, m_tick, m_led};
            total = total + 1;
            if (got !== want) begin
              bad = bad + 1;
              $display("FAIL outputs t=%0t frame=%0d phase=%0d got=%b want=%b", $time, frame_no, phase, got, want);
            end
          end
          if (reset_loc) tick_cnt = 0;
          else if (frame_tick) tick_cnt = tick_cnt + 1;
          if (mode_idx != prev_mode) mode_changes = mode_changes + 1;
          prev_mode = mode_idx;
        end
      end
    join_none

    // Reset state
    repeat (5) @(negedge clk);
    #1;
    check("reset_outputs", int'({mode_idx, mode_bit, color_3b, auto_en, frame_tick, led_ok}), 6'b000100);
    check("model_reset", int'({2'(m_mode), m_auto, m_led}), 4'b0010);
    reset_loc = 1'b0;
    cmp_en = 1;
    vs_run = 1;

    // Auto cycling: advances on ticks 4, 7, 10, 13
    wait_at(12, 50);
    check("auto_mode_f12", mode_idx, 3);
    check("auto_en_f12", auto_en, 1);
    check("model_mode_f12", m_mode, 3);
    wait_at(13, 50);
    check("auto_mode_f13", mode_idx, 0);
    check("auto_changes", mode_changes, 4);

    // Bouncing press: one press event, MANUAL, advance at next tick
    wait_at(14, 20);
    for (int i = 0; i < 10; i++) begin
      btn_next_n = (i % 2 != 0);
      repeat (2) @(negedge clk);
    end
    press_for(10);
    wait_at(15, 50);
    check("bounce_mode", mode_idx, 1);
    check("bounce_manual", auto_en, 0);
    wait_at(25, 50);
    check("manual_no_auto", mode_idx, 1);

    // Three presses in one frame collapse to one advance
    wait_at(26, 10); press_for(8);
    wait_at(26, 35); press_for(8);
    wait_at(26, 60); press_for(8);
    wait_at(27, 50);
    check("multi_press_mode", mode_idx, 2);
    wait_at(28, 50);
    check("multi_press_once", mode_idx, 2);

    // Long hold returns to AUTO; only the press itself advances
    wait_at(29, 20);
    btn_next_n = 1'b0;
    wait_at(31, 50);
    check("hold_auto", auto_en, 1);
    check("hold_mode", mode_idx, 3);
    wait_at(31, 70);
    btn_next_n = 1'b1;
    wait_at(34, 50);
    check("after_hold_mode", mode_idx, 3);
    wait_at(35, 50);
    check("after_hold_adv", mode_idx, 0);

    // Press event coinciding with dwell expiry (tick 37)
    wait_at(36, 97);
    btn_next_n = 1'b0;
    wait_at(37, 15);
    btn_next_n = 1'b1;
    wait_at(37, 50);
    check("expire_press_manual", auto_en, 0);
    check("expire_press_hold", mode_idx, 0);
    wait_at(38, 50);
    check("expire_press_adv", mode_idx, 1);
    wait_at(39, 50);
    check("expire_press_single", mode_idx, 1);

    // Press coinciding with frame_tick (tick 40) is deferred one frame
    wait_at(39, 97);
    btn_next_n = 1'b0;
    wait_at(40, 15);
    btn_next_n = 1'b1;
    wait_at(40, 50);
    check("tick_press_deferred", mode_idx, 1);
    wait_at(41, 50);
    check("tick_press_adv", mode_idx, 2);

    // Mid-frame reset, released while vsync is high
    reset_loc = 1'b1;
    #1;
    check("midreset_outputs", int'({mode_idx, mode_bit, color_3b, auto_en, frame_tick, led_ok}), 6'b000100);
    wait_at(42, 1);
    reset_loc = 1'b0;
    wait_at(42, 50);
    check("release_edge_ignored", tick_cnt, 0);
    wait_at(73, 50);
    check("led_before_32", led_ok, 0);
    check("ticks_31", tick_cnt, 31);
    wait_at(74, 50);
    check("led_at_32", led_ok, 1);
    check("ticks_32", tick_cnt, 32);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
